// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: definitions shared by the UART transmitter arbiter files.
//   state_t  - arbiter FSM encoding (2-bit)
//   grant_w  - width of a requester index for a given requester count
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    function automatic int grant_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search.
// Returns the first set bit of mask, starting at ptr and wrapping modulo NREQ.
//   mask   in  NREQ  candidate requests
//   ptr    in  GW    index where the search starts
//   winner out GW    index of the first candidate found (0 when none)
//   valid  out 1     at least one candidate present
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GW   = grant_w(NREQ)
) (
    input  logic [NREQ-1:0] mask,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   winner,
    output logic            valid
);

    always_comb begin
        int idx;
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!valid && mask[idx[GW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between NREQ
// byte sources, with packet locking.
// Optional watchdog in WAIT: define UART_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | arbitrate; capture the winner's byte
// START  | ack + tx_start pulse to the transmitter
// WAIT   | wait for tx_done_tick (or watchdog expiry)
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   req/req_data/req_last  per-requester byte handshake inputs
//   ack             one-cycle capture pulse per requester
//   tx_start/tx_din start pulse and byte to the transmitter
//   tx_done_tick    transmitter finished the byte
//   busy            high in START and WAIT
//   grant_id        last granted requester
//   locked          packet in progress
//   timeout_err     one-cycle watchdog pulse (always 0 without the macro)
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int DBIT        = 8,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*DBIT-1:0]       req_data,
    input  logic [NREQ-1:0]            req_last,
    output logic [NREQ-1:0]            ack,
    output logic                       tx_start,
    output logic [DBIT-1:0]            tx_din,
    input  logic                       tx_done_tick,
    output logic                       busy,
    output logic [grant_w(NREQ)-1:0]   grant_id,
    output logic                       locked,
    output logic                       timeout_err
);

    localparam int GW = grant_w(NREQ);

    if (NREQ < 2 || NREQ > 16 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end

    state_t          state;
    logic [GW-1:0]   ptr;
    logic            last_q;
    logic            abandon;
    logic [NREQ-1:0] cand_mask;
    logic [GW-1:0]   pick_ptr;
    logic [GW-1:0]   pick_id;
    logic            pick_valid;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] wd_cnt;
`endif

    function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + GW'(1);
    endfunction

    // A lock whose owner withdrew its request is dropped in the same IDLE
    // cycle; the search then restarts just past the abandoned requester.
    always_comb begin
        abandon   = (state == ST_IDLE) && locked && !req[grant_id];
        cand_mask = req;
        pick_ptr  = ptr;
        if (abandon)
            pick_ptr = next_idx(grant_id);
        else if (locked)
            cand_mask = req & (NREQ'(1) << grant_id);
    end

    rr_picker #(.NREQ(NREQ), .GW(GW)) u_pick (
        .mask   (cand_mask),
        .ptr    (pick_ptr),
        .winner (pick_id),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            last_q      <= 1'b0;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_din      <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            locked      <= 1'b0;
            timeout_err <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
        end else begin
            ack         <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (abandon) begin
                        locked <= 1'b0;
                        ptr    <= next_idx(grant_id);
                    end
                    if (pick_valid) begin
                        tx_din   <= req_data[pick_id*DBIT +: DBIT];
                        grant_id <= pick_id;
                        last_q   <= req_last[pick_id];
                        locked   <= !req_last[pick_id];
                        ack      <= NREQ'(1) << pick_id;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                    wd_cnt <= TW'(TIMEOUT_CYC - 1);
`endif
                end
                ST_WAIT: begin
                    // done takes priority over a simultaneous watchdog expiry
                    if (tx_done_tick) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (last_q) begin
                            locked <= 1'b0;
                            ptr    <= next_idx(grant_id);
                        end
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (wd_cnt == '0) begin
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        locked      <= 1'b0;
                        ptr         <= next_idx(grant_id);
                    end else begin
                        wd_cnt <= wd_cnt - TW'(1);
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        tx_done_tick;
    logic        busy;
    logic [1:0]  grant_id;
    logic        locked;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TIMEOUT_CYC(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .ack          (ack),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .grant_id     (grant_id),
        .locked       (locked),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int i, input logic [7:0] d, input logic last);
        req_data[i*8 +: 8] = d;
        req_last[i]        = last;
        req[i]             = 1'b1;
    endtask

    // Wait (bounded) for tx_start, then check the grant seen in START.
    task automatic grant_check(input string tag, input int id, input logic [7:0] d,
                               input logic lk, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!tx_start && waited < 300);
        chk({tag, "_start"}, 32'(tx_start), 32'd1);
        chk({tag, "_ack"}, 32'(ack), 32'(1) << id);
        chk({tag, "_gid"}, 32'(grant_id), 32'(id));
        chk({tag, "_din"}, 32'(tx_din), 32'(d));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_lock"}, 32'(locked), 32'(lk));
    endtask

    // Called in the START cycle: check pulses end, wait n cycles, send done.
    task automatic done_after(input string tag, input int n);
        tick();
        chk({tag, "_ack_off"}, 32'(ack), 32'd0);
        chk({tag, "_start_off"}, 32'(tx_start), 32'd0);
        repeat (n - 1) tick();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int w;
        int cnt;
        logic seen;
        rst_n        = 1'b0;
        req          = '0;
        req_data     = '0;
        req_last     = '0;
        tx_done_tick = 1'b0;
        repeat (3) tick();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_start", 32'(tx_start), 0);
        chk("rst_din", 32'(tx_din), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_lock", 32'(locked), 0);
        chk("rst_to", 32'(timeout_err), 0);
        rst_n = 1'b1;
        tick();

        // Fairness: all requesting, grants 0,1,2,3,0 back to back.
        for (int i = 0; i < 4; i++) put(i, 8'hC0 + 8'(i), 1'b1);
        for (int n = 0; n < 5; n++) begin
            grant_check("fair", n % 4, 8'hC0 + 8'(n % 4), 1'b0, w);
            chk("fair_latency", 32'(w), 1);
            if (n == 4) req = '0;
            done_after("fair", 3);
        end

        // Single byte on requester 2 (ptr=1 now).
        put(2, 8'h41, 1'b1);
        grant_check("single", 2, 8'h41, 1'b0, w);
        req[2] = 1'b0;
        done_after("single", 160);
        chk("single_lock", 32'(locked), 0);
        // ptr must be 3 now: requester 3 beats requester 0.
        put(0, 8'hD0, 1'b1);
        put(3, 8'hD3, 1'b1);
        grant_check("ptr3", 3, 8'hD3, 1'b0, w);
        req[3] = 1'b0;
        done_after("ptr3", 4);
        grant_check("ptr0", 0, 8'hD0, 1'b0, w);
        req[0] = 1'b0;
        done_after("ptr0", 4);

        // Packet lock on requester 1 with 0 and 3 waiting (ptr=1).
        put(0, 8'hA0, 1'b1);
        put(3, 8'hA3, 1'b1);
        put(1, 8'h10, 1'b0);
        grant_check("pkt0", 1, 8'h10, 1'b1, w);
        put(1, 8'h11, 1'b0);
        done_after("pkt0", 5);
        grant_check("pkt1", 1, 8'h11, 1'b1, w);
        put(1, 8'h12, 1'b1);
        done_after("pkt1", 5);
        grant_check("pkt2", 1, 8'h12, 1'b0, w);
        req[1] = 1'b0;
        done_after("pkt2", 5);
        grant_check("pkt_r3", 3, 8'hA3, 1'b0, w);
        req[3] = 1'b0;
        done_after("pkt_r3", 5);
        grant_check("pkt_r0", 0, 8'hA0, 1'b0, w);
        req[0] = 1'b0;
        done_after("pkt_r0", 5);

        // Abandoned lock (ptr=1): requester 2 locks, then withdraws.
        put(2, 8'h22, 1'b0);
        grant_check("abn", 2, 8'h22, 1'b1, w);
        req[2] = 1'b0;
        put(1, 8'h31, 1'b1);
        put(3, 8'h33, 1'b1);
        done_after("abn", 5);
        grant_check("abn_r3", 3, 8'h33, 1'b0, w);
        req[3] = 1'b0;
        done_after("abn_r3", 5);
        grant_check("abn_r1", 1, 8'h31, 1'b0, w);
        req[1] = 1'b0;
        done_after("abn_r1", 5);

        // Spurious done tick in IDLE.
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        tick();
        chk("spur_busy", 32'(busy), 0);
        chk("spur_start", 32'(tx_start), 0);

        // Reset in WAIT (ptr=2).
        put(2, 8'h55, 1'b0);
        grant_check("prerst", 2, 8'h55, 1'b1, w);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_din", 32'(tx_din), 0);
        chk("mid_rst_gid", 32'(grant_id), 0);
        chk("mid_rst_lock", 32'(locked), 0);
        chk("mid_rst_ack", 32'(ack), 0);
        req = '0;
        tick();
        rst_n = 1'b1;
        put(3, 8'h77, 1'b1);
        grant_check("postrst", 3, 8'h77, 1'b0, w);
        req[3] = 1'b0;
        done_after("postrst", 5);

        // Stalled transmitter (ptr=0): requester 1 locks, 0 and 2 pending.
        put(1, 8'h99, 1'b0);
        grant_check("stall", 1, 8'h99, 1'b1, w);
        req[1] = 1'b0;
        put(0, 8'hB0, 1'b1);
        put(2, 8'h5A, 1'b1);
        tick();
`ifdef UART_ARB_TIMEOUT_EN
        cnt = 0;
        while (!timeout_err && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("to_delay", 32'(cnt), 32);
        chk("to_pulse", 32'(timeout_err), 1);
        chk("to_busy", 32'(busy), 0);
        chk("to_lock", 32'(locked), 0);
        tick();
        chk("to_one_cycle", 32'(timeout_err), 0);
        chk("to_regrant", 32'(tx_start), 1);
        chk("to_regrant_id", 32'(grant_id), 2);
        chk("to_regrant_din", 32'(tx_din), 32'h5A);
        req[2] = 1'b0;
`else
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (timeout_err || !busy) seen = 1'b1;
        end
        chk("noto_hold", 32'(seen), 0);
        chk("noto_busy", 32'(busy), 1);
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        // Requester 1's lock is abandoned, pointer moves past it to 2.
        grant_check("noto_regrant", 2, 8'h5A, 1'b0, w);
        req[2] = 1'b0;
`endif
        done_after("after_stall", 5);
        grant_check("final", 0, 8'hB0, 1'b0, w);
        req[0] = 1'b0;
        done_after("final", 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
